// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: grant, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        ReqValid,
    output logic [NREQ-1:0]        ReqReady,
    input  logic [4*NREQ-1:0]      ReqOp,
    input  logic [NREQ*DATA_W-1:0] ReqA,
    input  logic [NREQ*DATA_W-1:0] ReqB,
    output logic [3:0]             AluOperation,
    output logic [DATA_W-1:0]      AluA,
    output logic [DATA_W-1:0]      AluB,
    input  logic [DATA_W-1:0]      AluResult,
    input  logic                   AluZero,
    output logic                   RespValid,
    input  logic                   RespReady,
    output logic                   RespId,
    output logic [DATA_W-1:0]      RespResult,
    output logic                   RespZero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [3:0]        op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              id_reg;
    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;

    logic [3:0]        req_op [NREQ];
    logic [DATA_W-1:0] req_a  [NREQ];
    logic [DATA_W-1:0] req_b  [NREQ];

    logic any_valid;
    logic gnt_id;
    logic grant;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_op[gi] = ReqOp[gi*4 +: 4];
            assign req_a[gi]  = ReqA[gi*DATA_W +: DATA_W];
            assign req_b[gi]  = ReqB[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign any_valid = |ReqValid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_id = ~ReqValid[0];
    end
`else
    logic last_gnt_reg;

    // Both valid: hand the ALU to whoever did not get it last time.
    always_comb begin
        gnt_id = ReqValid[1] & ~ReqValid[0];
        if (ReqValid[0] && ReqValid[1]) begin
            gnt_id = ~last_gnt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= 1'b1;
        end else if (grant) begin
            last_gnt_reg <= gnt_id;
        end
    end
`endif

    // Gating with rst_n keeps ReqReady low while reset is asserted.
    assign grant = rst_n && (state_reg == ST_IDLE) && any_valid;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign ReqReady[gi] = grant && (gnt_id == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (any_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (RespReady) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            id_reg <= 1'b0;
        end else if (grant) begin
            op_reg <= req_op[gnt_id];
            a_reg  <= req_a[gnt_id];
            b_reg  <= req_b[gnt_id];
            id_reg <= gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else if (state_reg == ST_EXEC) begin
            result_reg <= AluResult;
            zero_reg   <= AluZero;
        end
    end

    assign AluOperation = op_reg;
    assign AluA         = a_reg;
    assign AluB         = b_reg;
    assign RespValid    = (state_reg == ST_RESP);
    assign RespId       = id_reg;
    assign RespResult   = result_reg;
    assign RespZero     = zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    ReqValid = '0;
    logic [1:0]    ReqReady;
    logic [7:0]    ReqOp = '0;
    logic [63:0]   ReqA = '0;
    logic [63:0]   ReqB = '0;
    logic [3:0]    AluOperation;
    logic [DW-1:0] AluA, AluB, AluResult;
    logic          AluZero;
    logic          RespValid;
    logic          RespReady = 1'b0;
    logic          RespId;
    logic [DW-1:0] RespResult;
    logic          RespZero;

    int checks = 0;
    int errors = 0;
    int last_gnt = 1;
    int cyc = 0;
    int txn_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU sitting outside the arbiter.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return (a < b) ? 32'd1 : 32'd0;
            4'hC:    return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign AluResult = alu_f(AluOperation, AluA, AluB);
    assign AluZero   = (AluResult == '0);

    alu_arbiter #(.DATA_W(DW), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
        .AluOperation(AluOperation), .AluA(AluA), .AluB(AluB),
        .AluResult(AluResult), .AluZero(AluZero),
        .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
        .RespResult(RespResult), .RespZero(RespZero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_grant(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (last_gnt == 0) ? 1 : 0;
`endif
        end
        return v[1] ? 1 : 0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdy"},   64'(ReqReady), 64'd0);
        chk({tag, "_valid"}, 64'(RespValid), 64'd0);
        chk({tag, "_id"},    64'(RespId), 64'd0);
        chk({tag, "_res"},   64'(RespResult), 64'd0);
        chk({tag, "_zero"},  64'(RespZero), 64'd0);
        chk({tag, "_op"},    64'(AluOperation), 64'd0);
        chk({tag, "_a"},     64'(AluA), 64'd0);
        chk({tag, "_b"},     64'(AluB), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_txn(input logic [1:0] v, input logic [3:0] op0, input logic [3:0] op1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int hold, output int resp_cyc);
        int g;
        logic [1:0] exp_rdy;
        logic [3:0] eo;
        logic [31:0] ea, eb, er;
        ReqValid  = v;
        ReqOp     = {op1, op0};
        ReqA      = {a1, a0};
        ReqB      = {b1, b0};
        RespReady = 1'b0;
        g = pick_grant(v);
        last_gnt = g;
        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        eo = (g == 1) ? op1 : op0;
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        er = alu_f(eo, ea, eb);
        #1;
        chk("grant", 64'(ReqReady), 64'(exp_rdy));
        @(posedge clk); @(negedge clk);
        ReqValid  = 2'($urandom);
        ReqOp     = 8'($urandom);
        ReqA      = {$urandom, $urandom};
        ReqB      = {$urandom, $urandom};
        RespReady = 1'($urandom);
        #1;
        chk("exec_rdy",   64'(ReqReady), 64'd0);
        chk("exec_valid", 64'(RespValid), 64'd0);
        chk("alu_op",     64'(AluOperation), 64'(eo));
        chk("alu_a",      64'(AluA), 64'(ea));
        chk("alu_b",      64'(AluB), 64'(eb));
        @(posedge clk); @(negedge clk);
        RespReady = 1'b0;
        #1;
        resp_cyc = cyc;
        chk("resp_valid", 64'(RespValid), 64'd1);
        chk("resp_id",    64'(RespId), 64'(g));
        chk("resp_res",   64'(RespResult), 64'(er));
        chk("resp_zero",  64'(RespZero), 64'(er == 32'd0));
        chk("resp_rdy",   64'(ReqReady), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            ReqValid = 2'($urandom);
            #1;
            chk("hold_valid", 64'(RespValid), 64'd1);
            chk("hold_res",   64'(RespResult), 64'(er));
            chk("hold_rdy",   64'(ReqReady), 64'd0);
            chk("hold_op",    64'(AluOperation), 64'(eo));
        end
        RespReady = 1'b1;
        @(posedge clk); @(negedge clk);
        RespReady = 1'b0;
        ReqValid  = 2'b00;
        #1;
        chk("done_valid", 64'(RespValid), 64'd0);
        $display("txn %0d: valid=%b grant=%0d op=%h a=%h b=%h res=%h zero=%0d hold=%0d",
                 txn_no, v, g, eo, ea, eb, er, er == 32'd0, hold);
        txn_no++;
    endtask

    // Reset while the op is in EXEC (stage 0) or RESP (stage 1).
    task automatic reset_mid(input int stage);
        int g;
        ReqValid = 2'b11;
        ReqOp    = 8'h22;
        ReqA     = {32'd3, 32'd4};
        ReqB     = {32'd5, 32'd6};
        g = pick_grant(2'b11);
        last_gnt = g;
        @(posedge clk); @(negedge clk);
        if (stage == 1) begin
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero(stage == 0 ? "rst_exec" : "rst_resp");
        last_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            #1;
            chk("rst_novalid", 64'(RespValid), 64'd0);
        end
        ReqValid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        chk("post_rst_valid", 64'(RespValid), 64'd0);
        $display("reset during %s: in-flight op dropped", stage == 0 ? "EXEC" : "RESP");
    endtask

    initial begin
        int rc, prev_rc;
        logic [1:0] v;
        logic [3:0] o0, o1;
        logic [31:0] a0, b0, a1, b1;

        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(2'b01, 4'h2, 4'h0, 32'd5, 32'd7, 32'd0, 32'd0, 0, rc);
        chk("add_res", 64'(RespResult), 64'd12);

        // Both always valid: round-robin alternation, 3-cycle spacing.
        prev_rc = rc;
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, 4'h2, 4'h6, $urandom, $urandom, $urandom, $urandom, 0, rc);
            if (i > 0) chk("spacing", 64'(rc - prev_rc), 64'd3);
            prev_rc = rc;
        end

        do_txn(2'b10, 4'h0, 4'h6, 32'd1, 32'd2, 32'd9, 32'd9, 5, rc);
        do_txn(2'b01, 4'hF, 4'h0, 32'h1234, 32'h00FF, 32'd0, 32'd0, 1, rc);

        // No requests: nothing granted, nothing responded.
        ReqValid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_rdy",   64'(ReqReady), 64'd0);
            chk("idle_valid", 64'(RespValid), 64'd0);
            @(posedge clk); @(negedge clk);
        end

        reset_mid(0);
        do_txn(2'b11, 4'h1, 4'h2, 32'hA0, 32'h0B, 32'd1, 32'd1, 0, rc);
        reset_mid(1);
        do_txn(2'b11, 4'h7, 4'h2, 32'd1, 32'd9, 32'd1, 32'd1, 0, rc);

        for (int n = 0; n < 40; n++) begin
            v  = 2'($urandom_range(1, 3));
            o0 = 4'($urandom);
            o1 = 4'($urandom);
            a0 = $urandom; b0 = $urandom;
            a1 = $urandom; b1 = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                o0 = 4'h6; b0 = a0;
            end
            do_txn(v, o0, o1, a0, b0, a1, b1, $urandom_range(0, 3), rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have parameter: NREQ, 2, requester count (fixed at 2).
REQ-003 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ReqValid  in  2  per-requester request valid, bit i = requester i.
REQ-006 SHALL have port: ReqReady  out  2  per-requester accept, one-hot or zero.
REQ-007 SHALL have port: ReqOp  in  8  packed 4-bit ALU Operation codes, [3:0] = requester 0.
REQ-008 SHALL have port: ReqA / ReqB  in  2*DATA_W each  packed operands, low word = requester 0.
REQ-009 SHALL have port: AluOperation  out  4  Operation code to shared ALU.
REQ-010 SHALL have port: AluA / AluB  out  DATA_W each  operands to shared ALU.
REQ-011 SHALL have port: AluResult  in  DATA_W  shared ALU result, combinational from AluA/AluB/AluOperation.
REQ-012 SHALL have port: AluZero  in  1  shared ALU zero flag.
REQ-013 SHALL have port: RespValid  out  1  response valid.
REQ-014 SHALL have port: RespReady  in  1  response consumer ready.
REQ-015 SHALL have port: RespId  out  1  index of requester owning the response.
REQ-016 SHALL have port: RespResult / RespZero  out  DATA_W / 1  captured result and zero flag.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-018 IDLE: if any ReqValid, SHALL grant one requester, assert ReqReady[g] combinationally in that cycle, latch ReqOp/ReqA/ReqB of g and g into internal regs, go EXEC.
REQ-019 IDLE with ReqValid = 00: SHALL stay IDLE, ReqReady = 00.
REQ-020 ReqReady SHALL be 00 in EXEC and RESP; requests there SHALL be held off, not dropped.
REQ-021 EXEC: AluOperation/AluA/AluB SHALL drive latched values; at cycle end SHALL capture AluResult/AluZero into RespResult/RespZero; go RESP.
REQ-022 AluOperation/AluA/AluB SHALL be register outputs, stable in all states, changing only on a grant.
REQ-023 RESP: RespValid = 1, RespId/RespResult/RespZero stable until RespValid&&RespReady; on that edge go IDLE, RespValid deasserts next cycle.
REQ-024 Minimum per-op latency: grant cycle to RespValid = 2 cycles; back-to-back throughput 1 op per 3 cycles with RespReady held 1.
REQ-025 Operation codes SHALL pass through unmodified, including undefined codes; no decode in this block.
REQ-026 Arbitration (default): round-robin; pointer LastGnt updated on each grant; both valid -> grant requester != LastGnt; single valid -> grant it.
REQ-027 Result width: DATA_W, no truncation or extension.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ReqReady = 00, RespValid = 0, RespId = 0, RespResult = 0, RespZero = 0, AluOperation = 0, AluA = 0, AluB = 0, LastGnt = 1.
REQ-029 Reset mid-EXEC or mid-RESP SHALL discard the in-flight op with no response issued.
REQ-030 First grant after reset with both valid SHALL go to requester 0.

Configuration
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins when both valid; LastGnt unused.
REQ-032 Macro undefined: round-robin per REQ-026.

Verification
REQ-033 Reset, ReqValid=01, ReqOp[3:0]=0010, A=5, B=7, RespReady=1 -> ReqReady=01 same cycle, RespValid 2 cycles later, RespId=0, RespResult=12, RespZero=0.
REQ-034 ReqValid=11 held, RespReady=1 -> grants alternate 0,1,0,1; RespId sequence 0,1,0,1 at 3-cycle spacing (macro defined: 0,0,0,0).
REQ-035 Requester 1 op 0110, A=B=9, RespReady=0 for 5 cycles -> RespValid held 5 cycles, RespResult=0, RespZero=1, ReqReady=00 throughout.
REQ-036 rst_n low during EXEC -> RespValid never asserts; all outputs 0 asynchronously; next ReqValid=11 grants requester 0.
REQ-037 ReqOp=1111 (undefined) -> AluOperation=1111 during EXEC, response returned normally.
